// File: rtl/motion_map_packer_if.sv
// motion_map_packer_if: bus bundle for the motion map packer.
//   s_motion/s_valid/s_last/s_ready : 1-bit-per-pixel motion decision stream (input side)
//   m_tdata/m_nbits/m_tlast/m_tvalid/m_tready : AXI4-Stream packed word output
// Modports:
//   master : the packer view (consumes the pixel stream, drives the AXI-Stream words)
//   slave  : the environment view (drives pixels, consumes words)
// WORD_W must match the WORD_W of the attached packer.
interface motion_map_packer_if #(
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned NbW = $clog2(WORD_W + 1);

  logic              s_motion;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [WORD_W-1:0] m_tdata;
  logic [NbW-1:0]    m_nbits;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;

  modport master (
    input  s_motion, s_valid, s_last, m_tready,
    output s_ready, m_tdata, m_nbits, m_tlast, m_tvalid
  );

  modport slave (
    output s_motion, s_valid, s_last, m_tready,
    input  s_ready, m_tdata, m_nbits, m_tlast, m_tvalid
  );
endinterface

// File: rtl/motion_map_packer.sv
// motion_map_packer: packs the per-pixel motion decision bits LSB-first into WORD_W-bit words
// and emits them on an AXI4-Stream master, marking the word that holds the frame's last pixel.
// Optionally counts motion pixels per frame for the status path.
// Ports:
//   clk              : system clock
//   rst              : synchronous active-low reset
//   enb              : stage enable; while low no pixel is accepted, output keeps draining
//   bus              : motion_map_packer_if.master (pixel stream in, packed words out)
//   frame_motion_cnt : motion pixel count of the last completed frame
//   cnt_valid        : one-cycle pulse when frame_motion_cnt updates
// Build option: define MAP_PACKER_STATS_EN to include the motion counter; otherwise
// frame_motion_cnt and cnt_valid are tied to 0.
module motion_map_packer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  motion_map_packer_if.master   bus,
  output logic [CNT_W-1:0]      frame_motion_cnt,
  output logic                  cnt_valid
);
  localparam int unsigned IdxW = $clog2(WORD_W);
  localparam int unsigned NbW  = $clog2(WORD_W + 1);

  logic              accept, complete, slot_free;
  logic              run_q;
  logic [WORD_W-1:0] acc_q, acc_d, word;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NbW-1:0]    nbits;
  logic [WORD_W-1:0] out_data_q, out_data_d, pend_data_q, pend_data_d;
  logic [NbW-1:0]    out_nbits_q, out_nbits_d, pend_nbits_q, pend_nbits_d;
  logic              out_last_q, out_last_d, pend_last_q, pend_last_d;
  logic              out_valid_q, out_valid_d, pend_q, pend_d;

  // run_q keeps s_ready low while reset is held, even with enb high.
  assign bus.s_ready = enb && !pend_q && run_q;
  assign accept      = bus.s_valid && bus.s_ready;
  assign complete    = accept && ((idx_q == IdxW'(WORD_W - 1)) || bus.s_last);
  // The accumulator is cleared after every completed word, so bits above idx are already 0.
  assign word        = acc_q | (WORD_W'(bus.s_motion) << idx_q);
  assign nbits       = NbW'(idx_q) + NbW'(1);
  assign slot_free   = !out_valid_q || bus.m_tready;

  always_comb begin
    acc_d        = acc_q;
    idx_d        = idx_q;
    out_data_d   = out_data_q;
    out_nbits_d  = out_nbits_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    pend_nbits_d = pend_nbits_q;
    pend_last_d  = pend_last_q;

    if (accept) begin
      if (complete) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = word;
        idx_d = idx_q + IdxW'(1);
      end
    end

    if (slot_free) begin
      if (pend_q) begin
        // s_ready is low while pend is set, so no word can complete in this cycle.
        out_data_d  = pend_data_q;
        out_nbits_d = pend_nbits_q;
        out_last_d  = pend_last_q;
        out_valid_d = 1'b1;
        pend_d      = 1'b0;
      end else if (complete) begin
        out_data_d  = word;
        out_nbits_d = nbits;
        out_last_d  = bus.s_last;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (complete) begin
      pend_d       = 1'b1;
      pend_data_d  = word;
      pend_nbits_d = nbits;
      pend_last_d  = bus.s_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q        <= 1'b0;
      acc_q        <= '0;
      idx_q        <= '0;
      out_data_q   <= '0;
      out_nbits_q  <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_nbits_q <= '0;
      pend_last_q  <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      out_data_q   <= out_data_d;
      out_nbits_q  <= out_nbits_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_nbits_q <= pend_nbits_d;
      pend_last_q  <= pend_last_d;
    end
  end

  assign bus.m_tdata  = out_data_q;
  assign bus.m_nbits  = out_nbits_q;
  assign bus.m_tlast  = out_last_q;
  assign bus.m_tvalid = out_valid_q;

`ifdef MAP_PACKER_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, fmc_q, fmc_d;
  logic             cv_q, cv_d;

  always_comb begin
    cnt_inc = cnt_q;
    if (accept && bus.s_motion && (cnt_q != '1)) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
    cnt_d = cnt_inc;
    fmc_d = fmc_q;
    cv_d  = 1'b0;
    if (accept && bus.s_last) begin
      fmc_d = cnt_inc;
      cv_d  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      fmc_q <= '0;
      cv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fmc_q <= fmc_d;
      cv_q  <= cv_d;
    end
  end

  assign frame_motion_cnt = fmc_q;
  assign cnt_valid        = cv_q;
`else
  assign frame_motion_cnt = '0;
  assign cnt_valid        = 1'b0;
`endif
endmodule

// File: tb/tb_motion_map_packer.sv
// Bench for motion_map_packer: directed scenarios plus randomized frames, checked against a
// frame-level reference model (bit lists per word, ones-count per frame). A second instance
// with a 4-bit counter runs on the same stimulus to exercise counter saturation.
module tb_motion_map_packer;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned CNT_W_SAT = 4;
  localparam int unsigned NB_W      = 6;
`ifdef MAP_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [WORD_W-1:0] data;
    int unsigned       nbits;
    bit                last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b0;
  always #5 clk = ~clk;

  motion_map_packer_if #(.WORD_W(WORD_W)) bus ();
  motion_map_packer_if #(.WORD_W(WORD_W)) bus_sat ();

  logic [CNT_W-1:0]     fmc;
  logic                 cv;
  logic [CNT_W_SAT-1:0] fmc_sat;
  logic                 cv_sat;

  motion_map_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .enb              (enb),
    .bus              (bus),
    .frame_motion_cnt (fmc),
    .cnt_valid        (cv)
  );

  motion_map_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W_SAT)) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .enb              (enb),
    .bus              (bus_sat),
    .frame_motion_cnt (fmc_sat),
    .cnt_valid        (cv_sat)
  );

  assign bus_sat.s_motion = bus.s_motion;
  assign bus_sat.s_valid  = bus.s_valid;
  assign bus_sat.s_last   = bus.s_last;
  assign bus_sat.m_tready = bus.m_tready;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // ---------------- reference model and monitor ----------------
  bit          cur_bits[$];
  int unsigned ones;
  word_t       exp_q[$];
  bit          cnt_due;
  int unsigned due_ones;
  bit          hold_v;
  logic [63:0] hold_val;

  always @(negedge clk) begin
    if (!rst) begin
      cur_bits.delete();
      exp_q.delete();
      ones    = 0;
      cnt_due = 1'b0;
      hold_v  = 1'b0;
    end else begin
      check("sat_mirror",
            64'({bus_sat.s_ready, bus_sat.m_tvalid, bus_sat.m_tlast, bus_sat.m_nbits,
                 bus_sat.m_tdata}),
            64'({bus.s_ready, bus.m_tvalid, bus.m_tlast, bus.m_nbits, bus.m_tdata}));

      if (hold_v) begin
        check("hold_stable", 64'({bus.m_tvalid, bus.m_tlast, bus.m_nbits, bus.m_tdata}),
              hold_val);
      end
      hold_v   = bus.m_tvalid && !bus.m_tready;
      hold_val = 64'({bus.m_tvalid, bus.m_tlast, bus.m_nbits, bus.m_tdata});

      if (cnt_due) begin
        check("cnt_valid", 64'(cv), 64'(STATS));
        check("frame_cnt", 64'(fmc),
              STATS ? 64'((due_ones > (2**CNT_W - 1)) ? (2**CNT_W - 1) : due_ones) : 64'(0));
        check("cnt_valid_sat", 64'(cv_sat), 64'(STATS));
        check("frame_cnt_sat", 64'(fmc_sat),
              STATS ? 64'((due_ones > 15) ? 15 : due_ones) : 64'(0));
        cnt_due = 1'b0;
      end else begin
        check("cnt_valid_idle", 64'({cv, cv_sat}), 64'(0));
      end

      if (bus.m_tvalid && bus.m_tready) begin
        check("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          word_t w;
          w = exp_q.pop_front();
          check("word_data", 64'(bus.m_tdata), 64'(w.data));
          check("word_nbits", 64'(bus.m_nbits), 64'(w.nbits));
          check("word_last", 64'(bus.m_tlast), 64'(w.last));
        end
      end

      if (bus.s_valid && bus.s_ready) begin
        cur_bits.push_back(bus.s_motion);
        if (bus.s_motion) ones++;
        if (cur_bits.size() == WORD_W || bus.s_last) begin
          word_t w;
          w.data = '0;
          for (int i = 0; i < cur_bits.size(); i++) w.data[i] = cur_bits[i];
          w.nbits = cur_bits.size();
          w.last  = bus.s_last;
          exp_q.push_back(w);
          cur_bits.delete();
        end
        if (bus.s_last) begin
          cnt_due  = 1'b1;
          due_ones = ones;
          ones     = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_tready = 1'b0;
  bit rand_enb    = 1'b0;

  always @(posedge clk) begin
    if (rand_tready) begin
      #1;
      bus.m_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      n++;
      if (n > 1000) begin
        check("accept_timeout", 64'(bus.s_ready), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit bits[$], input bit with_last);
    for (int i = 0; i < bits.size(); i++) begin
      if (rand_enb && $urandom_range(0, 7) == 0) begin
        enb = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        enb = 1'b1;
      end
      bus.s_valid  = 1'b1;
      bus.s_motion = bits[i];
      bus.s_last   = with_last && (i == bits.size() - 1);
      wait_accept();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({bus.s_ready, bus.m_tvalid, bus.m_tlast, bus.m_nbits, bus.m_tdata}),
          64'(0));
    check({tag, "_cnt"}, 64'({fmc, cv}), 64'(0));
  endtask

  initial begin
    bit bits[$];
    int n;

    bus.s_valid  = 1'b0;
    bus.s_motion = 1'b0;
    bus.s_last   = 1'b0;
    bus.m_tready = 1'b1;
    enb = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 64-pixel alternating frame
    bits.delete();
    for (int i = 0; i < 64; i++) bits.push_back(i % 2 == 0);
    send_frame(bits, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // 5-pixel frame 1,1,0,0,1
    bits = '{1, 1, 0, 0, 1};
    send_frame(bits, 1'b1);
    @(negedge clk);
    check("t2_tvalid", 64'(bus.m_tvalid), 64'(1));
    check("t2_tdata", 64'(bus.m_tdata), 64'h13);
    check("t2_nbits", 64'(bus.m_nbits), 64'(5));
    check("t2_tlast", 64'(bus.m_tlast), 64'(1));
    check("t2_cnt", 64'({cv, fmc}), STATS ? 64'({1'b1, 20'd3}) : 64'(0));
    @(posedge clk);
    #1;

    // backpressure: 64 pixels with m_tready low, then release and finish the frame
    bus.m_tready = 1'b0;
    bits.delete();
    for (int i = 0; i < 96; i++) bits.push_back(i % 3 == 0);
    send_frame(bits[0:63], 1'b0);
    @(negedge clk);
    check("bp_sready", 64'(bus.s_ready), 64'(0));
    check("bp_tvalid", 64'(bus.m_tvalid), 64'(1));
    check("bp_tdata", 64'(bus.m_tdata), 64'h49249249);
    repeat (5) @(negedge clk);
    check("bp_sready_hold", 64'(bus.s_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.m_tready = 1'b1;
    send_frame(bits[64:95], 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // enb low mid-word after 7 pixels
    bits.delete();
    for (int i = 0; i < 32; i++) bits.push_back(1'($urandom_range(0, 1)));
    send_frame(bits[0:6], 1'b0);
    bus.s_valid  = 1'b1;
    bus.s_motion = bits[7];
    enb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("enb_low_sready", 64'(bus.s_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    enb = 1'b1;
    send_frame(bits[7:31], 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // reset mid-frame after 20 pixels
    bits.delete();
    for (int i = 0; i < 20; i++) bits.push_back(1'($urandom_range(0, 1)));
    send_frame(bits, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midframe_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    bits.delete();
    for (int i = 0; i < 32; i++) bits.push_back(1'b1);
    send_frame(bits, 1'b1);
    @(negedge clk);
    check("ones_word", 64'(bus.m_tdata), 64'hFFFF_FFFF);
    check("ones_last", 64'({bus.m_tvalid, bus.m_tlast}), 64'(3));
    @(posedge clk);
    #1;

    // 20-pixel all-ones frame: saturates the 4-bit counter instance
    bits.delete();
    for (int i = 0; i < 20; i++) bits.push_back(1'b1);
    send_frame(bits, 1'b1);
    @(negedge clk);
    check("sat_cnt", 64'({cv_sat, fmc_sat}), STATS ? 64'({1'b1, 4'd15}) : 64'(0));
    @(posedge clk);
    #1;

    // randomized frames with random backpressure and enable gaps
    rand_tready = 1'b1;
    rand_enb    = 1'b1;
    for (int f = 0; f < 12; f++) begin
      bits.delete();
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
      send_frame(bits, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_tready = 1'b0;
    rand_enb    = 1'b0;
    @(posedge clk);
    #2;
    bus.m_tready = 1'b1;
    enb = 1'b1;

    n = 0;
    while ((exp_q.size() != 0 || cnt_due) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_words", 64'(exp_q.size()), 64'(0));
    check("drain_tvalid", 64'(bus.m_tvalid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/motion_map_packer.md
Name: motion_map_packer

Overview:
- Downstream neighbour of the pipeline control/motion-detector stage.
- Consumes the 1-bit-per-pixel motion decision stream, which is accepted only while the control stage asserts map_manager_enb.
- Packs the bits LSB-first into WORD_W-bit words and emits them on an AXI4-Stream master with end-of-frame marking.
- Also produces a per-frame count of motion pixels for the AXI-Lite status path.

Parameters:
- WORD_W, 32, output word width in bits (power of 2, 8..64).
- CNT_W, 20, width of the per-frame motion pixel counter.

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-low reset
- enb  in  1  stage enable (driven from map_manager_enb)
- s_motion  in  1  motion bit for current pixel (1 = motion)
- s_valid  in  1  input pixel valid
- s_last  in  1  last pixel of frame
- s_ready  out  1  input accept
- m_tdata  out  WORD_W  packed motion word, pixel 0 of word at bit 0
- m_nbits  out  $clog2(WORD_W+1)  number of valid bits in m_tdata (1..WORD_W)
- m_tlast  out  1  word contains last pixel of frame
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream ready
- frame_motion_cnt  out  CNT_W  motion pixel count of last completed frame
- cnt_valid  out  1  one-cycle pulse when frame_motion_cnt updates

Behaviour:
- Reset (rst == 0 at posedge clk):
  - Outputs: s_ready = 0, m_tvalid = 0, m_tdata = 0, m_nbits = 0, m_tlast = 0, frame_motion_cnt = 0, cnt_valid = 0.
  - Internal: accumulator, bit index, pending flag and running counter cleared.
  - Reset mid-word or mid-frame discards partial data; no word is emitted.
- Accept: accept = s_valid && s_ready. s_ready = enb && !pend (combinational from registers and enb).
- Accumulation:
  - On accept, s_motion is written to acc[idx] and idx increments.
  - complete = accept && (idx == WORD_W-1 || s_last).
  - On complete, idx returns to 0 and accumulator bits above the written bit are zero in the emitted word.
- Output register (single slot) plus one pending-word slot (pend). Priority each cycle, evaluated when the slot is free (!m_tvalid || m_tready):
  1. If pend, load the pending word; pend clears.
  2. Else if complete, load directly; m_tvalid rises the cycle after the completing bit is accepted (latency 1).
  3. If complete and the slot is not free, the word goes to pend = 1 and s_ready drops next cycle.
- Loaded word fields:
  - m_nbits = idx+1 of the completing bit.
  - m_tlast = s_last of the completing bit.
- AXI rules:
  - m_tdata, m_nbits and m_tlast are stable while m_tvalid && !m_tready.
  - m_tvalid falls only after a handshake with no new load.
- Simultaneous events: a handshake and a new load in the same cycle keep m_tvalid high with the new word (back-to-back, full throughput).
- enb low:
  - s_ready = 0 and the accumulator holds its partial word; the frame resumes when enb returns.
  - The output side continues to drain independently of enb.
- Motion counter:
  - Increments on accept with s_motion = 1, saturating at 2^CNT_W-1.
  - On accept with s_last, frame_motion_cnt <= final count (including the current bit), cnt_valid pulses 1 cycle, and the running counter clears to 0.
- Boundary cases:
  - A single-pixel frame gives m_nbits = 1 and m_tlast = 1.
  - A frame length that is an exact multiple of WORD_W gives a final word with m_nbits = WORD_W and m_tlast = 1; no empty word is emitted.

Optional Feature:
- Macro: MAP_PACKER_STATS_EN.
- When defined: the motion counter, frame_motion_cnt and cnt_valid behave as above.
- When undefined: counter logic is omitted, and frame_motion_cnt = 0 and cnt_valid = 0 permanently; ports remain present.

Test Plan:
- Reset, then WORD_W=32, m_tready=1, enb=1, 64 pixels, s_motion alternating 1,0 starting 1, s_last on pixel 63 -> two words 0x55555555, m_nbits=32; tlast=0 then 1; frame_motion_cnt=32, one cnt_valid pulse.
- 5-pixel frame, bits 1,1,0,0,1 -> one word 0x00000013, m_nbits=5, m_tlast=1, cnt=3.
- m_tready=0 while streaming 96 continuous pixels -> first word held stable, second in pend, s_ready drops after pixel 63 accepted; on raising m_tready all three words delivered in order with no loss.
- enb toggled low for 10 cycles mid-word after 7 pixels -> s_ready=0 throughout; resumed word identical to the uninterrupted case.
- rst asserted low after 20 pixels of a frame -> all outputs 0 next cycle; a new 32-pixel all-ones frame yields 0xFFFFFFFF, tlast=1, cnt=32.
- CNT_W=4, 20-pixel all-ones frame -> frame_motion_cnt=15 (saturated); build without MAP_PACKER_STATS_EN -> cnt stays 0, cnt_valid never pulses.
